// File: rtl/vector_timing_sequencer.sv
// vector_timing_sequencer
// Replays a host-written vector memory, one vector per tester period, into
// NPINS double-buffered format-register slices.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   WR_EN/ADDR/DATA host write port into the vector memory (any state)
//   PERIOD/LEAD/TRAIL  timing config, latched on an accepted START
//   LAST_ADDR/LOOP  replay extent, latched on an accepted START
//   START/STOP      replay control
//   CYCLE           timing waveform, high while LEAD <= pc < TRAIL
//   LOAD/D          strobe and data for the next vector into pin buffers
//   TRANSFER        buffer-to-pin strobe at pc == 0
//   VEC_ADDR        index of the vector currently on the pins
//   BUSY/DONE/CFG_ERR  status
//   VEC_COUNT       (only with VECTOR_COUNT_EN) saturating transfer count
//
// Optional macro: VECTOR_COUNT_EN adds the VEC_COUNT output and counter.
//
// state  | meaning
// IDLE   | waiting for START; config validated here
// PRIME1 | reading vector 0
// PRIME2 | LOAD of vector 0 into the pin buffers
// RUN    | period counter active; TRANSFER at pc 0, next LOAD at pc 2
module vector_timing_sequencer #(
    parameter int NPINS = 8,
    parameter int AW    = 4,
    parameter int PW    = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR_EN,
    input  logic [AW-1:0]    WR_ADDR,
    input  logic [NPINS-1:0] WR_DATA,
    input  logic [PW-1:0]    PERIOD,
    input  logic [PW-1:0]    LEAD,
    input  logic [PW-1:0]    TRAIL,
    input  logic [AW-1:0]    LAST_ADDR,
    input  logic             LOOP,
    input  logic             START,
    input  logic             STOP,
    output logic             CYCLE,
    output logic             LOAD,
    output logic             TRANSFER,
    output logic [NPINS-1:0] D,
    output logic [AW-1:0]    VEC_ADDR,
    output logic             BUSY,
    output logic             DONE,
    output logic             CFG_ERR
`ifdef VECTOR_COUNT_EN
    ,
    output logic [15:0]      VEC_COUNT
`endif
);

    typedef enum logic [1:0] {IDLE, PRIME1, PRIME2, RUN} state_t;

    state_t            state;
    logic [NPINS-1:0]  mem [2**AW];

    logic [PW-1:0]     per_l, lead_l, trail_l;
    logic [AW-1:0]     last_l;
    logic              loop_l;
    logic [PW-1:0]     pc;
    logic [AW-1:0]     cur;
    logic              loaded;     // a LOAD was issued in the current period
    logic              stop_req;

    logic              cfg_ok;
    logic              has_next;
    logic [AW-1:0]     nxt;
    logic [PW-1:0]     pc_inc;
    logic              stop_now;
    logic              period_end;

    assign cfg_ok     = (PERIOD >= PW'(4)) && (LEAD >= PW'(2)) &&
                        (LEAD < TRAIL) && (TRAIL <= PERIOD);
    assign has_next   = (cur < last_l) || loop_l;
    assign nxt        = (cur == last_l) ? '0 : cur + 1'b1;
    assign pc_inc     = pc + 1'b1;
    assign stop_now   = stop_req | STOP;
    assign period_end = (pc == per_l - 1'b1);

    // No reset on the array; read-before-write falls out of the
    // non-blocking update, so a same-cycle read sees the old word.
    always_ff @(posedge CLK) begin
        if (WR_EN)
            mem[WR_ADDR] <= WR_DATA;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            CYCLE    <= 1'b0;
            LOAD     <= 1'b0;
            TRANSFER <= 1'b0;
            D        <= '0;
            VEC_ADDR <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            CFG_ERR  <= 1'b0;
            per_l    <= '0;
            lead_l   <= '0;
            trail_l  <= '0;
            last_l   <= '0;
            loop_l   <= 1'b0;
            pc       <= '0;
            cur      <= '0;
            loaded   <= 1'b0;
            stop_req <= 1'b0;
        end else begin
            LOAD     <= 1'b0;
            TRANSFER <= 1'b0;
            DONE     <= 1'b0;
            CFG_ERR  <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        if (cfg_ok) begin
                            per_l    <= PERIOD;
                            lead_l   <= LEAD;
                            trail_l  <= TRAIL;
                            last_l   <= LAST_ADDR;
                            loop_l   <= LOOP;
                            stop_req <= 1'b0;
                            BUSY     <= 1'b1;
                            state    <= PRIME1;
                        end else begin
                            CFG_ERR  <= 1'b1;
                        end
                    end
                end
                PRIME1: begin
                    LOAD  <= 1'b1;
                    D     <= mem[0];
                    state <= PRIME2;
                end
                PRIME2: begin
                    pc       <= '0;
                    cur      <= '0;
                    VEC_ADDR <= '0;
                    TRANSFER <= 1'b1;
                    loaded   <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    if (STOP)
                        stop_req <= 1'b1;
                    if (period_end) begin
                        // Without a LOAD this period there is nothing to
                        // transfer next, so the replay ends here.
                        CYCLE <= 1'b0;
                        if (!loaded || stop_now) begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end else begin
                            pc       <= '0;
                            cur      <= nxt;
                            VEC_ADDR <= nxt;
                            TRANSFER <= 1'b1;
                            loaded   <= 1'b0;
                        end
                    end else begin
                        pc    <= pc_inc;
                        CYCLE <= (pc_inc >= lead_l) && (pc_inc < trail_l);
                        if (pc_inc == PW'(2) && has_next && !stop_now) begin
                            LOAD   <= 1'b1;
                            D      <= mem[nxt];
                            loaded <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VECTOR_COUNT_EN
    logic transfer_go;
    assign transfer_go = (state == PRIME2) ||
                         ((state == RUN) && period_end && loaded && !stop_now);

    always_ff @(posedge CLK) begin
        if (RST)
            VEC_COUNT <= '0;
        else if (state == IDLE && START && cfg_ok)
            VEC_COUNT <= '0;
        else if (transfer_go && VEC_COUNT != 16'hFFFF)
            VEC_COUNT <= VEC_COUNT + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vector_timing_sequencer.sv
module tb_vector_timing_sequencer;

    localparam int NONE = -1000;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       WR_EN = 1'b0;
    logic [3:0] WR_ADDR = '0;
    logic [7:0] WR_DATA = '0;
    logic [7:0] PERIOD = 8'd6, LEAD = 8'd2, TRAIL = 8'd4;
    logic [3:0] LAST_ADDR = '0;
    logic       LOOP = 1'b0, START = 1'b0, STOP = 1'b0;
    logic       CYCLE, LOAD, TRANSFER, BUSY, DONE, CFG_ERR;
    logic [7:0] D;
    logic [3:0] VEC_ADDR;
`ifdef VECTOR_COUNT_EN
    logic [15:0] VEC_COUNT;
`endif

    vector_timing_sequencer #(.NPINS(8), .AW(4), .PW(8)) dut (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .PERIOD(PERIOD), .LEAD(LEAD), .TRAIL(TRAIL), .LAST_ADDR(LAST_ADDR),
        .LOOP(LOOP), .START(START), .STOP(STOP), .CYCLE(CYCLE), .LOAD(LOAD),
        .TRANSFER(TRANSFER), .D(D), .VEC_ADDR(VEC_ADDR), .BUSY(BUSY),
        .DONE(DONE), .CFG_ERR(CFG_ERR)
`ifdef VECTOR_COUNT_EN
        , .VEC_COUNT(VEC_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: memory image and the replay plan of one START.
    logic [7:0] model_mem [16];
    int m_per, m_ld, m_tr, m_last, m_lp, m_stop_r;

    // Vector shown in period p.
    function automatic int vidx(input int p);
        return (m_lp != 0) ? p % (m_last + 1) : p;
    endfunction

    // Is run-cycle r (cycles since the first TRANSFER) a LOAD cycle?
    function automatic bit exp_load(input int r);
        int p, pc;
        if (r < 0) return 1'b0;
        p  = r / m_per;
        pc = r % m_per;
        if (pc != 2) return 1'b0;
        if (m_lp == 0 && vidx(p) >= m_last) return 1'b0;
        if (m_stop_r >= 0 && p == m_stop_r / m_per && (m_stop_r % m_per) <= 1)
            return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic wr_mem(input int a, input int v);
        WR_EN = 1'b1; WR_ADDR = 4'(a); WR_DATA = 8'(v);
        model_mem[a] = 8'(v);
        tick();
        WR_EN = 1'b0;
    endtask

    // One START-to-DONE replay, checked every cycle against the period model.
    task automatic play(input int per, input int ld, input int tr, input int last,
                        input int lp, input int stop_r, input int wr_r,
                        input int wa, input int wd, input bit junk);
        int nper, total, r;
        logic [5:0] exp_f, got_f;
        logic [7:0] exp_d;
        exp_d = '0;
        m_per = per; m_ld = ld; m_tr = tr; m_last = last; m_lp = lp; m_stop_r = stop_r;
        nper  = (stop_r >= 0) ? stop_r / per + 1 : last + 1;
        total = nper * per;
        PERIOD = 8'(per); LEAD = 8'(ld); TRAIL = 8'(tr);
        LAST_ADDR = 4'(last); LOOP = lp[0];
        START = 1'b1;
        STOP  = junk;
        for (int k = 1; k <= total + 4; k++) begin
            tick();
            START = 1'b0; STOP = 1'b0; WR_EN = 1'b0;
            r = k - 3;
            exp_f[5] = (k <= 2) || (r >= 0 && r < total);                    // BUSY
            exp_f[4] = (k == 2) || (r >= 0 && r < total && exp_load(r));     // LOAD
            exp_f[3] = (r >= 0 && r < total && (r % per) == 0);              // TRANSFER
            exp_f[2] = (r >= 0 && r < total && (r % per) >= ld && (r % per) < tr); // CYCLE
            exp_f[1] = (r == total);                                         // DONE
            exp_f[0] = 1'b0;                                                 // CFG_ERR
            got_f = {BUSY, LOAD, TRANSFER, CYCLE, DONE, CFG_ERR};
            n_vec++;
            if (got_f !== exp_f) begin
                n_err++;
                $display("FAIL flags cyc%0d r=%0d: BUSY,LOAD,TRANSFER,CYCLE,DONE,CFG_ERR got %b want %b",
                         k, r, got_f, exp_f);
            end
            if (exp_f[4]) begin
                n_vec++;
                if (D !== exp_d) begin
                    n_err++;
                    $display("FAIL load_data r=%0d: D got %h want %h", r, D, exp_d);
                end
            end
            if (exp_f[3]) begin
                n_vec++;
                if (VEC_ADDR !== 4'(vidx(r / per))) begin
                    n_err++;
                    $display("FAIL vec_addr r=%0d: got %0d want %0d", r, VEC_ADDR, vidx(r / per));
                end
            end
`ifdef VECTOR_COUNT_EN
            begin
                int ec;
                ec = (r < 0) ? 0 : (((r < total) ? r : total - 1) / per + 1);
                n_vec++;
                if (VEC_COUNT !== 16'(ec)) begin
                    n_err++;
                    $display("FAIL vec_count r=%0d: got %0d want %0d", r, VEC_COUNT, ec);
                end
            end
`endif
            // Inputs for the cycle now starting; the model reads before writes.
            if (k == 1)
                exp_d = model_mem[0];
            else if (exp_load(r + 1))
                exp_d = model_mem[(vidx((r + 1) / per) + 1) % (last + 1)];
            if (r == stop_r) STOP = 1'b1;
            if (r == wr_r) begin
                WR_EN = 1'b1; WR_ADDR = 4'(wa); WR_DATA = 8'(wd);
                model_mem[wa] = 8'(wd);
            end
            if (junk && k <= 2) STOP = STOP | 1'($urandom % 2);
            if (junk && r < total) begin
                START  = 1'($urandom % 2);
                PERIOD = 8'($urandom); LEAD = 8'($urandom); TRAIL = 8'($urandom);
                LAST_ADDR = 4'($urandom); LOOP = 1'($urandom % 2);
            end
        end
        START = 1'b0; STOP = 1'b0; WR_EN = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        tick(); tick();
        n_vec++;
        if ({CYCLE, LOAD, TRANSFER, D, VEC_ADDR, BUSY, DONE, CFG_ERR} !== 19'd0) begin
            n_err++;
            $display("FAIL reset: outputs got %b want all zero",
                     {CYCLE, LOAD, TRANSFER, D, VEC_ADDR, BUSY, DONE, CFG_ERR});
        end
`ifdef VECTOR_COUNT_EN
        n_vec++;
        if (VEC_COUNT !== 16'd0) begin
            n_err++;
            $display("FAIL reset_count: got %0d want 0", VEC_COUNT);
        end
`endif
        RST = 1'b0;
        for (int i = 0; i < 16; i++) wr_mem(i, $urandom % 256);
        wr_mem(0, 8'hA5); wr_mem(1, 8'h3C); wr_mem(2, 8'hFF);
    endtask

    task automatic test_basic;
        play(6, 2, 4, 2, 0, NONE, NONE, 0, 0, 1'b0);
        play(4, 2, 4, 0, 0, NONE, NONE, 0, 0, 1'b0);   // single period, TRAIL == PERIOD
    endtask

    task automatic test_loop_stop;
        play(6, 2, 4, 2, 1, 3 * 6 + 4, NONE, 0, 0, 1'b1);
        play(6, 3, 6, 2, 1, 1 * 6 + 1, NONE, 0, 0, 1'b0);  // STOP before pc 2 suppresses LOAD
    endtask

    task automatic test_cfg_err;
        int cfg [4][3] = '{'{3, 2, 3}, '{6, 1, 4}, '{6, 2, 7}, '{6, 4, 4}};
        for (int i = 0; i < 4; i++) begin
            PERIOD = 8'(cfg[i][0]); LEAD = 8'(cfg[i][1]); TRAIL = 8'(cfg[i][2]);
            START = 1'b1;
            tick();
            START = 1'b0;
            for (int c = 0; c < 4; c++) begin
                n_vec++;
                if ({BUSY, LOAD, TRANSFER, CFG_ERR} !== {3'b000, (c == 0)}) begin
                    n_err++;
                    $display("FAIL cfg_err cfg%0d c%0d: BUSY,LOAD,TRANSFER,CFG_ERR got %b want %b",
                             i, c, {BUSY, LOAD, TRANSFER, CFG_ERR}, {3'b000, (c == 0)});
                end
                tick();
            end
        end
    endtask

    task automatic test_reset_mid_run;
        PERIOD = 8'd6; LEAD = 8'd2; TRAIL = 8'd4; LAST_ADDR = 4'd2; LOOP = 1'b1;
        START = 1'b1;
        for (int k = 1; k <= 6 + 6; k++) begin
            tick();
            START = 1'b0;
        end
        RST = 1'b1;                       // held during pc 3 of period 1
        tick();
        RST = 1'b0;
        n_vec++;
        if ({CYCLE, LOAD, TRANSFER, D, VEC_ADDR, BUSY, DONE, CFG_ERR} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_mid_run: outputs got %b want all zero",
                     {CYCLE, LOAD, TRANSFER, D, VEC_ADDR, BUSY, DONE, CFG_ERR});
        end
        play(6, 2, 4, 2, 0, NONE, NONE, 0, 0, 1'b0);
    endtask

    task automatic test_collision;
        // write mem[1] in the very cycle it is read (period 0, pc 1)
        play(6, 2, 4, 2, 1, 4 * 6 + 4, 1, 1, 8'h00, 1'b0);
        wr_mem(1, 8'h3C);
    endtask

    task automatic test_random;
        for (int it = 0; it < 10; it++) begin
            int per, ld, tr, last, lp, stop_r, wr_r;
            for (int a = 0; a < 16; a++) wr_mem(a, $urandom % 256);
            per  = 4 + $urandom % 9;
            ld   = 2 + $urandom % (per - 2);
            tr   = ld + 1 + $urandom % (per - ld);
            last = $urandom % 6;
            lp   = $urandom % 2;
            if (lp != 0)
                stop_r = $urandom % ((last + 1) * per * 2);
            else
                stop_r = ($urandom % 2) ? int'($urandom % ((last + 1) * per)) : NONE;
            wr_r = $urandom % ((last + 1) * per);
            play(per, ld, tr, last, lp, stop_r, wr_r, $urandom % (last + 1),
                 $urandom % 256, 1'($urandom % 2));
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_loop_stop();
        test_cfg_err();
        test_reset_mid_run();
        test_collision();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
